// File: rtl/lcd_frame_driver.sv
// HD44780-style 8-bit character LCD driver with a 2 x COLS frame buffer.
// Runs the power-on init sequence, then streams the buffer to the panel whenever it is
// dirty or a refresh is requested. Every bus byte occupies SLOT clocks with a real E strobe.
module lcd_frame_driver #(
    parameter int unsigned COLS     = 16,
    parameter int unsigned AW       = 6,
    parameter int unsigned SLOT     = 4,
    parameter int unsigned PWR_WAIT = 70,
    parameter int unsigned CMD_WAIT = 30,
    parameter int unsigned CLR_WAIT = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          refresh_req,
    output logic          busy,
    output logic          frame_done,
    output logic          LCD_E,
    output logic          LCD_RS,
    output logic          LCD_RW,
    output logic [7:0]    LCD_DATA
);

    localparam int unsigned DEPTH   = 2 * COLS;
    localparam int unsigned CMD_LEN = SLOT + CMD_WAIT;
    localparam int unsigned CLR_LEN = SLOT + CLR_WAIT;
    localparam int unsigned CMAX1   = (PWR_WAIT > CMD_LEN) ? PWR_WAIT : CMD_LEN;
    localparam int unsigned CMAX    = (CMAX1 > CLR_LEN) ? CMAX1 : CLR_LEN;
    localparam int unsigned CW      = $clog2(CMAX + 1);
    // idx also walks the four init commands, so it needs at least two bits
    localparam int unsigned IW      = ($clog2(COLS) > 2) ? $clog2(COLS) : 2;

    localparam logic [CW-1:0] PWR_LAST  = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_LEN - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_LEN - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] E_LAST    = CW'(SLOT - 2);
    localparam logic [IW-1:0] COL_LAST  = IW'(COLS - 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(3);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StPwr,
        StInit,
        StIdle,
        StAddr1,
        StLine1,
        StAddr2,
        StLine2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            dirty_q, dirty_d;
    logic            booted_q, booted_d;
    logic            fd_q, fd_d;
    logic            e_q, e_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      char_q [DEPTH];

    logic            wr_valid;
    logic            dirty_clr;
    logic            slot_end;
    logic            in_slot;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_char;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = 8'h06;
            default: c = 8'h01;
        endcase
        return c;
    endfunction

    assign wr_valid = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign slot_end = (cnt_q == SLOT_LAST);

    // Sequencer: power wait, init commands with their waits, then frame byte slots.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        fd_d      = 1'b0;
        dirty_clr = 1'b0;
        case (state_q)
            StPwr: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StInit: begin
                // Clear display (last command) needs the longer settle time
                if (cnt_q == ((idx_q == INIT_LAST) ? CLR_LAST : CMD_LAST)) begin
                    cnt_d = '0;
                    if (idx_q == INIT_LAST) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StIdle: begin
                if (dirty_q || refresh_req) begin
                    state_d   = StAddr1;
                    cnt_d     = '0;
                    idx_d     = '0;
                    dirty_clr = 1'b1;
                end
            end
            StAddr1: begin
                if (slot_end) begin
                    state_d = StLine1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StLine1: begin
                if (slot_end) begin
                    cnt_d = '0;
                    if (idx_q == COL_LAST) begin
                        state_d = StAddr2;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StAddr2: begin
                if (slot_end) begin
                    state_d = StLine2;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StLine2: begin
                if (slot_end) begin
                    cnt_d = '0;
                    if (idx_q == COL_LAST) begin
                        state_d = StIdle;
                        fd_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StPwr;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Dirty tracking: a valid write wins over the clear taken when a frame starts.
    always_comb begin
        dirty_d  = dirty_q;
        if (dirty_clr) begin
            dirty_d = 1'b0;
        end
        if (wr_valid) begin
            dirty_d = 1'b1;
        end
        booted_d = booted_q | fd_d;
    end

    // Buffer read port, addressed by the byte that the next cycle will launch.
    always_comb begin
        rd_addr = AW'(idx_d);
        if (state_d == StLine2) begin
            rd_addr = AW'(COLS) + AW'(idx_d);
        end
        rd_char = 8'h20;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_char = char_q[i];
            end
        end
    end

    // Bus outputs are registered from next-state so E, RS and DATA change cleanly on edges.
    always_comb begin
        e_d     = 1'b0;
        rs_d    = rs_q;
        data_d  = data_q;
        in_slot = (state_d != StPwr) && (state_d != StIdle) && (cnt_d <= SLOT_LAST);
        if (in_slot && (cnt_d != '0) && (cnt_d <= E_LAST)) begin
            e_d = 1'b1;
        end
        if (in_slot && (cnt_d == '0)) begin
            case (state_d)
                StInit: begin
                    rs_d   = 1'b0;
                    data_d = init_cmd(idx_d[1:0]);
                end
                StAddr1: begin
                    rs_d   = 1'b0;
                    data_d = 8'h80;
                end
                StAddr2: begin
                    rs_d   = 1'b0;
                    data_d = 8'hC0;
                end
                default: begin
                    rs_d   = 1'b1;
                    data_d = rd_char;
                end
            endcase
        end
    end

    // Control and bus registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StPwr;
            cnt_q    <= '0;
            idx_q    <= '0;
            dirty_q  <= 1'b1;
            booted_q <= 1'b0;
            fd_q     <= 1'b0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dirty_q  <= dirty_d;
            booted_q <= booted_d;
            fd_q     <= fd_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
        end
    end

    // Character buffer; every entry returns to a space on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                char_q[i] <= 8'h20;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_valid && (wr_addr == AW'(i))) begin
                    char_q[i] <= wr_data;
                end
            end
        end
    end

    // Busy stays up through the first frame after init, then only while a frame runs.
    assign busy       = (state_q != StIdle) || !booted_q;
    assign frame_done = fd_q;
    assign LCD_E      = e_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_DATA   = data_q;

endmodule

// File: doc/lcd_frame_driver.md
Name: lcd_frame_driver

Overview:
- Parametrised successor to the fixed-text HD44780 character-LCD driver: 8-bit-bus controller with a 2-line x COLS character frame buffer written through a simple write port.
- Performs the power-on init sequence, then refreshes the panel only when the buffer is dirty or a refresh is requested.
- Generates a real E strobe per byte slot instead of forwarding the system clock; clock/time display logic and status logic write characters through wr_* instead of being hard-coded here.

Parameters:
COLS, 16, characters per line (2..40); buffer depth is 2*COLS
AW, 6, wr_addr width; must satisfy 2^AW >= 2*COLS
SLOT, 4, clock cycles per bus byte (>= 3)
PWR_WAIT, 70, cycles held idle after reset before the first command
CMD_WAIT, 30, extra cycles after each init command except clear
CLR_WAIT, 40, extra cycles after the clear-display command

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  0..COLS-1 = line 1; COLS..2*COLS-1 = line 2
wr_data  in  8  ASCII character
refresh_req  in  1  forces one frame refresh when idle
busy  out  1  high from reset until init completes, and during every frame
frame_done  out  1  one-cycle pulse when a frame completes
LCD_E  out  1  enable strobe
LCD_RS  out  1  register select (0 = command, 1 = data)
LCD_RW  out  1  read/write; always 0
LCD_DATA  out  8  bus data

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst). While rst is low:
  - state = PWR; all buffer bytes = 0x20; dirty = 1
  - LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00
  - busy = 1, frame_done = 0
- Reset asserted mid-frame or mid-init aborts immediately; the full init sequence reruns after release.
- States: PWR -> INIT -> IDLE -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> IDLE.
- PWR: counts PWR_WAIT cycles, bus held at 0, then goes to INIT.
- INIT: sends 0x38, 0x0C, 0x06, 0x01 in that order, each with RS = 0.
  - After each of the first three: CMD_WAIT idle cycles.
  - After 0x01: CLR_WAIT idle cycles.
  - Then enters IDLE.
- Byte slot (slot counter s = 0..SLOT-1):
  - RS and DATA are registered at s = 0 and held for the whole slot.
  - LCD_E = 1 for s = 1..SLOT-2 and 0 at s = 0 and s = SLOT-1, giving setup and hold around the falling edge.
  - Between slots and during waits, E = 0 and RS/DATA keep their last values.
- IDLE:
  - busy = 0.
  - If dirty = 1 or refresh_req = 1: clear dirty and go to ADDR1 on the next cycle.
- Frame contents:
  - ADDR1: 0x80, RS = 0.
  - LINE1: COLS data slots, RS = 1, buffer[0..COLS-1].
  - ADDR2: 0xC0, RS = 0.
  - LINE2: COLS data slots, buffer[COLS..2*COLS-1].
  - No extra waits inside a frame. Frame length = (2*COLS + 2)*SLOT cycles; 136 cycles at defaults.
- Frame end: on the last cycle of the last LINE2 slot, go to IDLE; frame_done = 1 for exactly that next cycle.
- Buffer write port:
  - Writes are accepted every cycle in every state except reset; buffer is written at the clk edge where wr_en = 1.
  - wr_addr >= 2*COLS: write ignored; dirty unchanged.
  - A valid write sets dirty = 1.
  - A write in the same cycle IDLE clears dirty: the set wins and dirty stays 1.
  - A write during a frame sets dirty, so a second frame follows immediately after frame_done.
  - A character is sampled from the buffer at its slot's s = 0. A write to a position already sent appears in the next frame; a write to a position not yet sent appears in this frame.
- refresh_req is ignored outside IDLE and is not queued.
- LCD_RW is constant 0; there is no busy-flag read.

Test Plan:
- Reset release, defaults -> bus held 0 for 70 cycles; then 0x38, 0x0C, 0x06 (RS = 0) spaced SLOT+30 cycles apart and 0x01 followed by 40 idle cycles; an initial all-0x20 frame follows; busy falls only after frame_done.
- Write 0x41 to addr 0 and 0x5A to addr 31 from IDLE -> one frame of 0x80, 'A', 15 x 0x20, 0xC0, 15 x 0x20, 'Z'; frame_done pulses once, 136 cycles after busy rises.
- Check E timing at SLOT = 4 -> E high exactly 2 cycles per slot; RS/DATA stable from 1 cycle before E rises to 1 cycle after E falls; 34 E pulses per frame.
- Write addr 2 = 0x42 during LINE2 of a frame -> second frame starts the cycle after frame_done with 'B' at line-1 column 2; write to addr 40 (invalid) in IDLE -> no frame starts.
- refresh_req = 1 in IDLE with a clean buffer -> one identical frame; refresh_req held high for one cycle mid-frame -> no extra frame.
- Assert rst during LINE1 -> E = 0, DATA = 0x00, busy = 1 asynchronously; buffer returns to 0x20; full PWR/INIT sequence repeats after release.
